// File: rtl/taxi_eth_mac_swap_loopback.sv
// Ethernet loopback: exchanges destination and source MAC of each received
// frame and forwards it to the transmit stream; runt frames are dropped.
module taxi_eth_mac_swap_loopback #(
  parameter int ID_W   = 8,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [ID_W-1:0]   s_axis_tid,
  input  logic [USER_W-1:0] s_axis_tuser,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [ID_W-1:0]   m_axis_tid,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              stat_frame_swapped,
  output logic              stat_frame_runt
);

  localparam int unsigned HDR_LEN  = 12;
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] SWAP_OFS = CNT_W'(HDR_LEN / 2);

  typedef enum logic [1:0] {CAPTURE, EMIT, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          hdr_q [HDR_LEN];
  logic [7:0]          hdr_d [HDR_LEN];
  logic [ID_W-1:0]     tid_q, tid_d;
  logic                hlast_q, hlast_d;
  logic [USER_W-1:0]   huser_q, huser_d;
  logic [7:0]          m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic [USER_W-1:0]   m_user_q, m_user_d;
  logic [ID_W-1:0]     m_tid_q, m_tid_d;
  logic                swapped_q, swapped_d;
  logic                runt_q, runt_d;

  logic                s_hs_c;
  logic                m_hs_c;
  logic [CNT_W-1:0]    emit_k_c;
  logic [CNT_W-1:0]    emit_idx_c;

  // Input is accepted while capturing, or in payload when the output register
  // can take a byte and is not holding the frame's final byte.
  assign s_axis_tready = !rst && ((state_q == CAPTURE) ||
                         ((state_q == PAYLOAD) &&
                          (!m_valid_q || (m_axis_tready && !m_last_q))));
  assign s_hs_c     = s_axis_tvalid && s_axis_tready;
  assign m_hs_c     = m_valid_q && m_axis_tready;
  assign emit_k_c   = cnt_q + CNT_W'(1);
  assign emit_idx_c = (emit_k_c < SWAP_OFS) ? (emit_k_c + SWAP_OFS) : (emit_k_c - SWAP_OFS);

  assign m_axis_tdata       = m_data_q;
  assign m_axis_tvalid      = m_valid_q;
  assign m_axis_tlast       = m_last_q;
  assign m_axis_tuser       = m_user_q;
  assign m_axis_tid         = m_tid_q;
  assign stat_frame_swapped = swapped_q;
  assign stat_frame_runt    = runt_q;

  // Next-state logic: header capture, swapped header emission, payload pass-through.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    tid_d     = tid_q;
    hlast_d   = hlast_q;
    huser_d   = huser_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    m_tid_d   = m_tid_q;
    swapped_d = m_hs_c && m_last_q;
    runt_d    = 1'b0;

    case (state_q)
      CAPTURE: begin
        if (s_hs_c) begin
          hdr_d[cnt_q] = s_axis_tdata;
          if (cnt_q == '0) begin
            tid_d = s_axis_tid;
          end
          if (cnt_q == LAST_IDX) begin
            // Header complete: present the first swapped byte next cycle.
            state_d   = EMIT;
            cnt_d     = '0;
            hlast_d   = s_axis_tlast;
            huser_d   = s_axis_tuser;
            m_valid_d = 1'b1;
            m_data_d  = hdr_q[SWAP_OFS];
            m_last_d  = 1'b0;
            m_user_d  = '0;
            m_tid_d   = tid_q;
          end else if (s_axis_tlast) begin
            cnt_d  = '0;
            runt_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        if (m_hs_c) begin
          if (cnt_q == LAST_IDX) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            cnt_d     = '0;
            state_d   = hlast_q ? CAPTURE : PAYLOAD;
          end else begin
            cnt_d    = emit_k_c;
            m_data_d = hdr_q[emit_idx_c];
            m_last_d = (emit_k_c == LAST_IDX) && hlast_q;
            m_user_d = (emit_k_c == LAST_IDX) ? huser_q : '0;
          end
        end
      end
      PAYLOAD: begin
        if (s_hs_c) begin
          m_valid_d = 1'b1;
          m_data_d  = s_axis_tdata;
          m_last_d  = s_axis_tlast;
          m_user_d  = s_axis_tuser;
          m_tid_d   = tid_q;
        end else if (m_hs_c) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            state_d = CAPTURE;
          end
        end
      end
      default: begin
        state_d = CAPTURE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CAPTURE;
      cnt_q     <= '0;
      hdr_q     <= '{default: '0};
      tid_q     <= '0;
      hlast_q   <= 1'b0;
      huser_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      m_tid_q   <= '0;
      swapped_q <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      tid_q     <= tid_d;
      hlast_q   <= hlast_d;
      huser_q   <= huser_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      m_tid_q   <= m_tid_d;
      swapped_q <= swapped_d;
      runt_q    <= runt_d;
    end
  end

endmodule

// File: tb/tb_taxi_eth_mac_swap_loopback.sv
// Bench for the MAC-swap loopback: directed and random frames against a
// frame-level reference model of the swapped output stream.
module tb_taxi_eth_mac_swap_loopback;

  localparam int ID_W   = 8;
  localparam int USER_W = 1;
  localparam int TMO    = 20000;

  typedef logic [ID_W+USER_W+9-1:0] word_t;  // {tid, user, last, data}

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic [ID_W-1:0]   s_tid = '0;
  logic [USER_W-1:0] s_tuser = '0;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic [ID_W-1:0]   m_tid;
  logic [USER_W-1:0] m_tuser;
  logic              st_swap;
  logic              st_runt;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int    n_swap = 0, n_runt = 0, n_valid = 0, stab_err = 0;
  bit    prev_stall = 0;
  word_t prev_word = '0;
  word_t out_q[$];
  word_t exp_q[$];
  int    tlast_cyc_q[$];
  logic [7:0] frame_q[$];
  int    first_acc_cyc, acc12_cyc, last_acc_cyc;

  taxi_eth_mac_swap_loopback #(.ID_W(ID_W), .USER_W(USER_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tuser(m_tuser),
    .stat_frame_swapped(st_swap), .stat_frame_runt(st_runt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: collects handshaken words, stat pulses and stall stability.
  always @(negedge clk) begin
    word_t cur;
    cur = {m_tid, m_tuser, m_tlast, m_tdata};
    if (st_swap) n_swap++;
    if (st_runt) n_runt++;
    if (m_tvalid) n_valid++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!m_tvalid || cur !== prev_word)) stab_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_word  = cur;
      if (m_tvalid && m_tready) begin
        out_q.push_back(cur);
        if (m_tlast) tlast_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_frame(input int len);
    frame_q.delete();
    for (int k = 0; k < len; k++) frame_q.push_back(8'($urandom));
  endtask

  // Reference model: header halves exchanged, rest in order; tuser/tlast on the last byte.
  task automatic model_frame(input logic [ID_W-1:0] tid, input logic [USER_W-1:0] bad);
    int len;
    len = frame_q.size();
    if (len < 12) return;
    for (int k = 0; k < len; k++) begin
      int src;
      src = (k < 12) ? ((k + 6) % 12) : k;
      exp_q.push_back({tid, (k == len - 1) ? bad : USER_W'(0), k == len - 1, frame_q[src]});
    end
  endtask

  // Drives frame_q on s_axis; called and returns at posedge+1.
  task automatic send_frame(input logic [ID_W-1:0] tid, input logic [USER_W-1:0] bad, input bit gaps);
    int len;
    bit acc;
    len = frame_q.size();
    for (int k = 0; k < len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tdata  = frame_q[k];
      s_tlast  = (k == len - 1);
      s_tuser  = (k == len - 1) ? bad : USER_W'(0);
      s_tid    = (k == 0) ? tid : ID_W'($urandom);
      s_tvalid = 1'b1;
      acc = 0;
      for (int t = 0; t < 1000 && !acc; t++) begin
        @(negedge clk);
        if (s_tready) begin
          acc = 1;
          if (k == 0) first_acc_cyc = cyc;
          if (k == 12) acc12_cyc = cyc;
          last_acc_cyc = cyc;
        end
        @(posedge clk); #1;
      end
      if (!acc) begin
        check("input_accept_timeout", 64'(acc), 64'(1));
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    model_frame(tid, bad);
  endtask

  task automatic drain();
    for (int t = 0; t < TMO && out_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input string tag);
    int bad_i;
    int n;
    check({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    bad_i = -1;
    for (int i = 0; i < n; i++) begin
      if (out_q[i] !== exp_q[i]) begin
        bad_i = i;
        break;
      end
    end
    checks++;
    assert (bad_i == -1) else begin
      errors++;
      $error("FAIL %s_data: word %0d observed %h expected %h", tag, bad_i, out_q[bad_i], exp_q[bad_i]);
    end
  endtask

  task automatic clear_q();
    out_q.delete();
    exp_q.delete();
    tlast_cyc_q.delete();
  endtask

  initial begin
    int sw0, rn0, v0, st0;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata", 64'(m_tdata), 64'(0));
    check("rst_m_tlast", 64'(m_tlast), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_stats", 64'({st_swap, st_runt}), 64'(0));
    rst = 1'b0;
    #1;
    check("tready_after_rst", 64'(s_tready), 64'(1));
    @(posedge clk); #1;

    // 64-byte frame with fixed MACs, downstream always ready
    rdy_mode = 1;
    clear_q();
    sw0 = n_swap;
    make_frame(64);
    frame_q[0] = 8'h02; frame_q[1] = 8'h00; frame_q[2] = 8'h00;
    frame_q[3] = 8'h00; frame_q[4] = 8'h00; frame_q[5] = 8'h01;
    frame_q[6] = 8'h02; frame_q[7] = 8'h00; frame_q[8] = 8'h00;
    frame_q[9] = 8'h00; frame_q[10] = 8'h00; frame_q[11] = 8'h02;
    send_frame(8'h5A, 1'b0, 1'b0);
    drain();
    check_stream("f64");
    if (out_q.size() == 64) begin
      b = out_q[5][7:0];
      check("f64_dst_lsb", 64'(b), 64'(8'h02));
      b = out_q[11][7:0];
      check("f64_src_lsb", 64'(b), 64'(8'h01));
    end
    check("f64_swap_pulses", 64'(n_swap - sw0), 64'(1));
    check("f64_payload_rate", 64'(last_acc_cyc - acc12_cyc), 64'(51));

    // Runt frames (5 and 11 bytes) then normal frames
    clear_q();
    rn0 = n_runt; v0 = n_valid; sw0 = n_swap;
    make_frame(5);
    send_frame(8'h11, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    check("runt5_pulse", 64'(n_runt - rn0), 64'(1));
    check("runt5_no_valid", 64'(n_valid - v0), 64'(0));
    make_frame(64);
    send_frame(8'h22, 1'b0, 1'b0);
    make_frame(11);
    send_frame(8'h33, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    check("runt11_pulse", 64'(n_runt - rn0), 64'(2));
    // Exactly 12 bytes, bad-frame flag on last byte
    make_frame(12);
    send_frame(8'h44, 1'b1, 1'b0);
    drain();
    check_stream("runt_then_frames");
    check("runt_then_swap_pulses", 64'(n_swap - sw0), 64'(2));

    // Reset while emitting header byte 5
    clear_q();
    make_frame(12);
    send_frame(8'h66, 1'b0, 1'b0);
    check("emit_latency_valid", 64'(m_tvalid), 64'(1));
    check("emit_byte0", 64'(m_tdata), 64'(frame_q[6]));
    repeat (5) @(posedge clk);
    #1;
    check("emit_byte5", 64'(m_tdata), 64'(frame_q[11]));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_valid", 64'(m_tvalid), 64'(0));
    check("midreset_tready", 64'(s_tready), 64'(0));
    rst = 1'b0;
    #1;
    check("midreset_tready_after", 64'(s_tready), 64'(1));
    @(posedge clk); #1;
    clear_q();
    make_frame(40);
    send_frame(8'h77, 1'b0, 1'b0);
    drain();
    check_stream("after_reset");

    // Two 60-byte frames back to back
    clear_q();
    make_frame(60);
    send_frame(8'h81, 1'b0, 1'b0);
    make_frame(60);
    send_frame(8'h82, 1'b0, 1'b0);
    drain();
    check_stream("b2b");
    check("b2b_tlasts", 64'(tlast_cyc_q.size()), 64'(2));
    if (tlast_cyc_q.size() >= 1)
      check("b2b_first_accept", 64'(first_acc_cyc), 64'(tlast_cyc_q[0] + 1));

    // 100 random frames, random ready, random input gaps
    clear_q();
    rdy_mode = 2;
    sw0 = n_swap; rn0 = n_runt; st0 = stab_err;
    for (int i = 0; i < 100; i++) begin
      int len;
      len = (i == 0) ? 1518 : (i == 1) ? 12 : $urandom_range(12, 300);
      make_frame(len);
      send_frame(ID_W'($urandom), USER_W'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    check_stream("rand100");
    check("rand_swap_pulses", 64'(n_swap - sw0), 64'(100));
    check("rand_no_runt", 64'(n_runt - rn0), 64'(0));
    check("rand_stall_stable", 64'(stab_err - st0), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_eth_mac_swap_loopback.md
TAXI_ETH_MAC_SWAP_LOOPBACK -- requirements
Module: taxi_eth_mac_swap_loopback

Interface
REQ-001 The block SHALL have parameter ID_W, default 8, meaning the tid width carried through unchanged.
REQ-002 The block SHALL have parameter USER_W, default 1, meaning the tuser width; bit 0 is the bad-frame flag.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is synchronous to its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Ports s_axis_tdata (input, 8), s_axis_tvalid (input, 1), s_axis_tready (output, 1), s_axis_tlast (input, 1), s_axis_tid (input, ID_W), s_axis_tuser (input, USER_W): the received-frame stream from the MAC RX FIFO.
REQ-006 Ports m_axis_tdata (output, 8), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1), m_axis_tid (output, ID_W), m_axis_tuser (output, USER_W): the transmit-frame stream to the MAC TX FIFO.
REQ-007 Port stat_frame_swapped, output, 1 bit: one-cycle pulse when the last byte of a forwarded frame is accepted on m_axis.
REQ-008 Port stat_frame_runt, output, 1 bit: one-cycle pulse when a frame shorter than 12 bytes is dropped.

Function
REQ-009 The block SHALL forward each input frame with bytes 0-5 (destination MAC) and bytes 6-11 (source MAC) exchanged; byte 12 onward SHALL pass unchanged and in order.
REQ-010 The FSM SHALL have states CAPTURE, EMIT and PAYLOAD, with CAPTURE entered on reset.
REQ-011 CAPTURE: s_axis_tready=1 and m_axis_tvalid=0; each accepted byte SHALL be stored in hdr[cnt], and the 4-bit cnt SHALL increment.
REQ-012 CAPTURE: tid SHALL be latched from the first byte of the frame (cnt=0) and held for the whole frame.
REQ-013 CAPTURE -> EMIT SHALL occur on acceptance of byte 11 (cnt=11), with cnt reset to 0.
REQ-014 If tlast is accepted in CAPTURE with cnt<11, the frame SHALL be discarded, stat_frame_runt SHALL pulse the next cycle, and the FSM SHALL stay in CAPTURE with cnt=0.
REQ-015 EMIT: s_axis_tready=0; output byte k SHALL be hdr[(k+6) mod 12] for k=0..11, each advancing only when m_axis_tvalid && m_axis_tready.
REQ-016 The first EMIT byte SHALL be valid on m_axis in the cycle after byte 11 is accepted (1-cycle latency).
REQ-017 If byte 11 carried tlast, EMIT byte 11 SHALL carry m_axis_tlast=1 and that byte's tuser, and the FSM SHALL return to CAPTURE afterwards; otherwise EMIT -> PAYLOAD after byte 11 is accepted downstream.
REQ-018 EMIT: bytes 0-10 SHALL carry tuser=0 and tlast=0.
REQ-019 PAYLOAD: a single output register SHALL be used, with s_axis_tready = !m_axis_tvalid || m_axis_tready; tdata, tlast and tuser SHALL pass through registered with 1-cycle latency.
REQ-020 PAYLOAD -> CAPTURE SHALL occur when a byte with tlast is accepted downstream; s_axis_tready SHALL be 0 from acceptance of tlast on s_axis until that byte leaves m_axis.
REQ-021 m_axis_tvalid, once asserted, SHALL NOT deassert, and data SHALL NOT change, until m_axis_tready=1 (AXI-Stream stability).
REQ-022 Full throughput SHALL be achieved: in PAYLOAD with m_axis_tready held at 1, one byte SHALL be transferred per cycle.
REQ-023 Back-to-back frames SHALL be supported: the first byte of the next frame SHALL be accepted in the cycle after the previous tlast leaves m_axis.

Reset
REQ-024 On rst=1 the block SHALL set: state=CAPTURE, cnt=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, m_axis_tid=0, s_axis_tready=0, and both stat pulses to 0.
REQ-025 On rst=1 the block SHALL discard any partially captured or partially emitted frame.
REQ-026 s_axis_tready SHALL assert in the first cycle after rst deasserts.

Verification
REQ-027 64-byte frame, dst=02:00:00:00:00:01, src=02:00:00:00:00:02, tready held at 1 -> output dst=02:..:02 and src=02:..:01, bytes 12-63 identical to the input, 64 bytes total, one stat_frame_swapped pulse.
REQ-028 5-byte frame with tlast on byte 4 -> no m_axis_tvalid, one stat_frame_runt pulse, and the following 64-byte frame is forwarded correctly.
REQ-029 Exactly 12-byte frame with tuser=1 on the last byte -> 12 swapped bytes out, tlast and tuser=1 on output byte 11 only.
REQ-030 Random m_axis_tready (50% duty) over 100 frames of 12-1518 bytes -> byte-exact swapped output, tvalid and data stable while stalled, and tid per frame matches its input.
REQ-031 rst asserted during EMIT byte 5 -> m_axis_tvalid=0 the next cycle, and the next frame is output swapped with no residue.
REQ-032 Two 60-byte frames back-to-back with tready held at 1 -> the second frame's first input byte is accepted in the cycle after the first frame's tlast output handshake.
